// File: rtl/fetch_unit.sv
// Dual-issue fetch stage: PC generation, paired instruction-memory requests and a
// circular fetch queue feeding decode, with flush-and-restart on a taken branch.
module fetch_unit #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned QDEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 isbranchtaken,
  input  logic [PC_W-1:0]      branchpc,
  output logic                 imem_req,
  output logic [PC_W-1:0]      imem_addr,
  input  logic [2*INSTR_W-1:0] imem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [INSTR_W-1:0]   out_instr0,
  output logic [INSTR_W-1:0]   out_instr1
);

  localparam int unsigned PtrW = $clog2(QDEPTH);
  localparam int unsigned CntW = $clog2(QDEPTH + 1);

  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    tag_q;
  logic               inflight_q;
  logic [CntW-1:0]    count_q;
  logic [PtrW-1:0]    head_q;
  logic [PtrW-1:0]    tail_q;
  logic [PC_W-1:0]    q_pc_q [QDEPTH];
  logic [INSTR_W-1:0] q_i0_q [QDEPTH];
  logic [INSTR_W-1:0] q_i1_q [QDEPTH];

  logic [CntW:0] occ;
  logic          issue_ok;
  logic          enq;
  logic          deq;

  always_comb begin
    // Occupancy counts the outstanding response but not a same-cycle dequeue, so
    // imem_req never depends on out_ready.
    occ       = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
    issue_ok  = occ < (CntW + 1)'(QDEPTH);
    imem_req  = ~reset & (isbranchtaken | issue_ok);
    imem_addr = reset ? '0 : (isbranchtaken ? branchpc : pc_q);
    out_valid = ~isbranchtaken & (count_q != '0);
    deq       = out_valid & out_ready;
    enq       = inflight_q & ~isbranchtaken;
    out_pc    = q_pc_q[head_q];
    out_instr0 = q_i0_q[head_q];
    out_instr1 = q_i1_q[head_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= '0;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        q_pc_q[i] <= '0;
        q_i0_q[i] <= '0;
        q_i1_q[i] <= '0;
      end
    end else if (isbranchtaken) begin
      // Flush: the in-flight response and any head advance are dropped.
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b1;
      tag_q      <= branchpc;
      pc_q       <= branchpc + PC_W'(2);
    end else begin
      inflight_q <= issue_ok;
      if (issue_ok) begin
        tag_q <= pc_q;
        pc_q  <= pc_q + PC_W'(2);
      end
      if (enq) begin
        q_pc_q[tail_q] <= tag_q;
        q_i0_q[tail_q] <= imem_rdata[INSTR_W-1:0];
        q_i1_q[tail_q] <= imem_rdata[2*INSTR_W-1:INSTR_W];
        tail_q         <= tail_q + PtrW'(1);
      end
      if (deq) begin
        head_q <= head_q + PtrW'(1);
      end
      if (enq && !deq) begin
        count_q <= count_q + CntW'(1);
      end else if (!enq && deq) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Front-end fetch stage that generates the program counter, requests instruction pairs from instruction memory, and buffers them for decode. It consumes the registered redirect (`branchpc`, `isbranchtaken`) from the execute unit, flushes wrong-path work and restarts fetch at the branch target. It supplies two instructions per entry to the dual-issue decode stage through a valid/ready handshake.

## Interface
- `PC_W`, 16: PC / instruction-address width.
- `INSTR_W`, 32: width of one instruction.
- `QDEPTH`, 4: fetch-queue entries (power of two, ≥2).

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `isbranchtaken`  in  1  redirect request from execute.
- `branchpc`  in  PC_W  redirect target; valid when `isbranchtaken`=1.
- `imem_req`  out  1  fetch request this cycle.
- `imem_addr`  out  PC_W  address of first instruction of the pair.
- `imem_rdata`  in  2*INSTR_W  pair: [INSTR_W-1:0] at addr, upper half at addr+1; valid exactly one cycle after `imem_req`.
- `out_valid`  out  1  queue head holds a pair.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_pc`  out  PC_W  PC of `out_instr0`.
- `out_instr0`  out  INSTR_W  older instruction.
- `out_instr1`  out  INSTR_W  younger instruction (PC = `out_pc`+1).

## Operation
- State: `pc` register, `inflight` bit (request issued last cycle), circular queue (QDEPTH entries of {pc, instr0, instr1}), head/tail pointers, `count` (0..QDEPTH).
- Reset values: `pc`=0, `inflight`=0, `count`=0, pointers=0; outputs `imem_req`=0, `imem_addr`=0, `out_valid`=0, `out_pc`/`out_instr*`=0.
- Issue (no redirect): `imem_req`=1 iff `count`+`inflight` < QDEPTH, counted before any same-cycle dequeue; `imem_addr`=`pc`; on issue `pc` ← `pc`+2 modulo 2^PC_W (0xFFFE → 0x0000 for PC_W=16).
- Response: when `inflight`=1 and no redirect, `imem_rdata` is written at tail together with the PC of the request (held in a one-entry tag register); `count` increments.
- Dequeue: `out_valid`=(`count`≠0); head fields are driven from the queue registers; `out_valid`&&`out_ready` advances the head and decrements `count`.
- Simultaneous enqueue and dequeue: both occur, `count` unchanged.
- Redirect (`isbranchtaken`=1), priority over everything except reset:
  - Queue flushed (`count`←0, pointers reset). Any same-cycle dequeue is ignored, and `out_valid` is forced to 0 in that cycle.
  - A response arriving in the redirect cycle is discarded.
  - Request issued in the same cycle: `imem_req`=1, `imem_addr`=`branchpc`; `pc` ← `branchpc`+2; `inflight`←1.
  - Odd targets are legal; the pair is {branchpc, branchpc+1}.
- Reset mid-operation: all state clears at once. The in-flight response arriving after reset deassertion is ignored because `inflight`=0.

## Timing
- Request in cycle t → data captured at end of t+1 → `out_valid`=1 in t+2.
- After reset release, the first request goes out in cycle 0 at address 0 and the first `out_valid` is in cycle 2.
- Redirect asserted in cycle r → target pair visible at head in r+2.
- Steady state with `out_ready`=1: one pair per cycle, no bubbles.
- With `out_ready`=0 the queue fills to QDEPTH, and `imem_req` drops once `count`+`inflight`=QDEPTH. Requests resume the cycle after a dequeue frees a slot.
- Outputs are registered or derived directly from registers; no combinational path from `out_ready` to `imem_req`.

## Test plan
- **Reset, then `out_ready`=1, memory returns {addr+1, addr}:** `imem_addr` = 0, 2, 4…; `out_valid` first in cycle 2 with `out_pc`=0, `out_instr0`=0, `out_instr1`=1, followed by `out_pc`=2, 4 on consecutive cycles.
- **Backpressure (`out_ready`=0 from cycle 0):** exactly 4 requests (0, 2, 4, 6) issue and `imem_req` stays 0. Raising `out_ready` drains `out_pc` 0, 2, 4, 6 in order, and fetch resumes at 8 with no lost or duplicated pair.
- **Redirect (`isbranchtaken`=1, `branchpc`=0x0041) while 3 entries are queued and a response is in flight:** `out_valid`=0 in that cycle; the queue empties and the stale response is dropped; `imem_addr`=0x0041 in the same cycle; the next head has `out_pc`=0x0041 two cycles later, followed by 0x0043.
- **Redirect coinciding with `out_valid`&&`out_ready`:** no pair is delivered that cycle, and the head advance does not corrupt the post-flush order.
- **Wrap-around (`branchpc`=0xFFFE):** pairs are fetched at 0xFFFE, then 0x0000, 0x0002.
- **Reset asserted mid-stream with a request in flight:** all outputs are 0 immediately. After release, fetch restarts at 0, and the stale `imem_rdata` returned in the cycle after release never reaches the queue.
